// File: rtl/osl_host_fifo.sv
// -----------------------------------------------------------------------------
// osl_host_fifo
//
// Host-side adapter for the OSL serial link. It sits between the CPU bus decode
// and the host_* word port of the link block, and the whole module runs in a
// single clock domain.
//   - TX FIFO: buffers CPU words. A drain FSM hands each word to the link as a
//     one-cycle link_wr pulse, with a guard cycle between pulses.
//   - RX FIFO: a fill FSM takes received link words with a one-cycle link_rd
//     pulse and buffers them for the CPU. The head of the RX FIFO is shown on
//     cpu_dout (first-word-fall-through).
//
// Ports
//   clk, resetb              clock; asynchronous active-low reset
//   cpu_wr, cpu_din          push into the TX FIFO; cpu_full = TX FIFO full
//   cpu_rd, cpu_dout         pop the RX FIFO head; cpu_empty = RX FIFO empty
//   tx_level, rx_level       FIFO occupancy, 0..depth
//   err_clr                  clears the sticky tx_ovf / rx_unf flags
//   tx_ovf                   sticky: cpu_wr while the TX FIFO was full
//   rx_unf                   sticky: cpu_rd while the RX FIFO was empty
//   link_wr, link_dout       to the link host_wr / host_din
//   link_dir                 from host_dir: the link can accept a word
//   link_rd                  to the link host_rd
//   link_din, link_dor       from host_dout / host_dor
// -----------------------------------------------------------------------------
module osl_host_fifo #(
    parameter int WORDSZ    = 8,
    parameter int TXDEPTHL2 = 2,
    parameter int RXDEPTHL2 = 2
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 cpu_wr,
    input  logic [WORDSZ-1:0]    cpu_din,
    output logic                 cpu_full,
    input  logic                 cpu_rd,
    output logic [WORDSZ-1:0]    cpu_dout,
    output logic                 cpu_empty,
    output logic [TXDEPTHL2:0]   tx_level,
    output logic [RXDEPTHL2:0]   rx_level,
    input  logic                 err_clr,
    output logic                 tx_ovf,
    output logic                 rx_unf,
    output logic                 link_wr,
    output logic [WORDSZ-1:0]    link_dout,
    input  logic                 link_dir,
    output logic                 link_rd,
    input  logic [WORDSZ-1:0]    link_din,
    input  logic                 link_dor
);

    localparam int TXDEPTH = 1 << TXDEPTHL2;
    localparam int RXDEPTH = 1 << RXDEPTHL2;

    localparam logic [TXDEPTHL2:0]   TX_FULL_LVL = TXDEPTH[TXDEPTHL2:0];
    localparam logic [RXDEPTHL2:0]   RX_FULL_LVL = RXDEPTH[RXDEPTHL2:0];
    localparam logic [TXDEPTHL2-1:0] TX_PTR_INC  = TXDEPTHL2'(1);
    localparam logic [RXDEPTHL2-1:0] RX_PTR_INC  = RXDEPTHL2'(1);
    localparam logic [TXDEPTHL2:0]   TX_LVL_INC  = (TXDEPTHL2 + 1)'(1);
    localparam logic [RXDEPTHL2:0]   RX_LVL_INC  = (RXDEPTHL2 + 1)'(1);

    typedef enum logic [1:0] {
        TXD_IDLE = 2'd0,
        TXD_WR   = 2'd1,
        TXD_HOLD = 2'd2
    } txd_state_e;

    typedef enum logic [1:0] {
        RXF_IDLE = 2'd0,
        RXF_RD   = 2'd1,
        RXF_HOLD = 2'd2
    } rxf_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WORDSZ-1:0]    tx_mem_q [TXDEPTH];
    logic [WORDSZ-1:0]    rx_mem_q [RXDEPTH];

    logic [TXDEPTHL2-1:0] tx_wptr_q, tx_wptr_d;
    logic [TXDEPTHL2-1:0] tx_rptr_q, tx_rptr_d;
    logic [TXDEPTHL2:0]   tx_level_q, tx_level_d;
    logic [RXDEPTHL2-1:0] rx_wptr_q, rx_wptr_d;
    logic [RXDEPTHL2-1:0] rx_rptr_q, rx_rptr_d;
    logic [RXDEPTHL2:0]   rx_level_q, rx_level_d;

    txd_state_e           txd_state_q, txd_state_d;
    rxf_state_e           rxf_state_q, rxf_state_d;

    logic                 link_wr_q, link_wr_d;
    logic [WORDSZ-1:0]    link_dout_q, link_dout_d;
    logic                 link_rd_q, link_rd_d;
    logic                 tx_ovf_q, tx_ovf_d;
    logic                 rx_unf_q, rx_unf_d;

    // ------------------------------------------------------------------
    // Handshake decode. Full/empty come straight from the registered
    // levels, so a write to a full FIFO is refused even when the drain
    // pops in the same cycle.
    // ------------------------------------------------------------------
    logic tx_full, tx_empty, tx_push, tx_pop, tx_ovf_set;
    logic rx_full, rx_empty, rx_push, rx_pop, rx_unf_set;

    assign tx_full    = (tx_level_q == TX_FULL_LVL);
    assign tx_empty   = (tx_level_q == '0);
    assign tx_push    = cpu_wr & ~tx_full;
    assign tx_ovf_set = cpu_wr & tx_full;
    assign tx_pop     = (txd_state_q == TXD_IDLE) & ~tx_empty & link_dir;

    assign rx_full    = (rx_level_q == RX_FULL_LVL);
    assign rx_empty   = (rx_level_q == '0);
    // The word is taken in the cycle link_rd is high; the link keeps
    // link_din valid until it has seen link_rd.
    assign rx_push    = (rxf_state_q == RXF_RD);
    assign rx_pop     = cpu_rd & ~rx_empty;
    assign rx_unf_set = cpu_rd & rx_empty;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        tx_wptr_d   = tx_wptr_q;
        tx_rptr_d   = tx_rptr_q;
        tx_level_d  = tx_level_q;
        txd_state_d = txd_state_q;
        link_wr_d   = 1'b0;
        link_dout_d = link_dout_q;

        if (tx_push) begin
            tx_wptr_d = tx_wptr_q + TX_PTR_INC;
        end
        if (tx_pop) begin
            tx_rptr_d   = tx_rptr_q + TX_PTR_INC;
            link_dout_d = tx_mem_q[tx_rptr_q];
        end
        if (tx_push && !tx_pop) begin
            tx_level_d = tx_level_q + TX_LVL_INC;
        end else if (!tx_push && tx_pop) begin
            tx_level_d = tx_level_q - TX_LVL_INC;
        end

        // Drain: pop -> one cycle of link_wr -> one guard cycle.
        // This gives a minimum spacing of 3 cycles between link_wr pulses.
        case (txd_state_q)
            TXD_IDLE: begin
                if (tx_pop) begin
                    txd_state_d = TXD_WR;
                    link_wr_d   = 1'b1;
                end
            end
            TXD_WR:   txd_state_d = TXD_HOLD;
            TXD_HOLD: txd_state_d = TXD_IDLE;
            default:  txd_state_d = TXD_IDLE;
        endcase
    end

    always_comb begin
        rx_wptr_d   = rx_wptr_q;
        rx_rptr_d   = rx_rptr_q;
        rx_level_d  = rx_level_q;
        rxf_state_d = rxf_state_q;
        link_rd_d   = 1'b0;

        if (rx_push) begin
            rx_wptr_d = rx_wptr_q + RX_PTR_INC;
        end
        if (rx_pop) begin
            rx_rptr_d = rx_rptr_q + RX_PTR_INC;
        end
        if (rx_push && !rx_pop) begin
            rx_level_d = rx_level_q + RX_LVL_INC;
        end else if (!rx_push && rx_pop) begin
            rx_level_d = rx_level_q - RX_LVL_INC;
        end

        // Only one fill is ever in flight, so a free slot seen in IDLE is
        // still free when the word arrives. While the FIFO is full,
        // link_rd is withheld and the link keeps its word.
        case (rxf_state_q)
            RXF_IDLE: begin
                if (link_dor && !rx_full) begin
                    rxf_state_d = RXF_RD;
                    link_rd_d   = 1'b1;
                end
            end
            RXF_RD:   rxf_state_d = RXF_HOLD;
            RXF_HOLD: rxf_state_d = RXF_IDLE;
            default:  rxf_state_d = RXF_IDLE;
        endcase
    end

    // A new error event takes priority over a clear in the same cycle.
    always_comb begin
        tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~err_clr);
        rx_unf_d = rx_unf_set | (rx_unf_q & ~err_clr);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            tx_level_q  <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            rx_level_q  <= '0;
            txd_state_q <= TXD_IDLE;
            rxf_state_q <= RXF_IDLE;
            link_wr_q   <= 1'b0;
            link_dout_q <= '0;
            link_rd_q   <= 1'b0;
            tx_ovf_q    <= 1'b0;
            rx_unf_q    <= 1'b0;
        end else begin
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            tx_level_q  <= tx_level_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            rx_level_q  <= rx_level_d;
            txd_state_q <= txd_state_d;
            rxf_state_q <= rxf_state_d;
            link_wr_q   <= link_wr_d;
            link_dout_q <= link_dout_d;
            link_rd_q   <= link_rd_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_unf_q    <= rx_unf_d;
        end
    end

    // Storage arrays carry no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= cpu_din;
        end
        if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= link_din;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cpu_full  = tx_full;
    assign cpu_empty = rx_empty;
    // Gated so that an empty FIFO (including just after reset) shows zero
    // rather than stale or uninitialised storage.
    assign cpu_dout  = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
    assign tx_level  = tx_level_q;
    assign rx_level  = rx_level_q;
    assign tx_ovf    = tx_ovf_q;
    assign rx_unf    = rx_unf_q;
    assign link_wr   = link_wr_q;
    assign link_dout = link_dout_q;
    assign link_rd   = link_rd_q;

endmodule

// File: tb/tb_osl_host_fifo.sv
// -----------------------------------------------------------------------------
// tb_osl_host_fifo
//
// Self-checking bench for osl_host_fifo. A reference model built from queues
// tracks the words accepted into each FIFO, the order the link must see them,
// the occupancies, and the sticky flags. A small link-partner model supplies
// received words and holds each word until link_rd consumes it. Directed
// scenarios run first, then randomised traffic, then a drain.
// -----------------------------------------------------------------------------
module tb_osl_host_fifo;

    localparam int TXD = 4;
    localparam int RXD = 4;

    logic       clk;
    logic       resetb;
    logic       cpu_wr;
    logic [7:0] cpu_din;
    logic       cpu_full;
    logic       cpu_rd;
    logic [7:0] cpu_dout;
    logic       cpu_empty;
    logic [2:0] tx_level;
    logic [2:0] rx_level;
    logic       err_clr;
    logic       tx_ovf;
    logic       rx_unf;
    logic       link_wr;
    logic [7:0] link_dout;
    logic       link_dir;
    logic       link_rd;
    logic [7:0] link_din;
    logic       link_dor;

    osl_host_fifo #(
        .WORDSZ    (8),
        .TXDEPTHL2 (2),
        .RXDEPTHL2 (2)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .cpu_wr    (cpu_wr),
        .cpu_din   (cpu_din),
        .cpu_full  (cpu_full),
        .cpu_rd    (cpu_rd),
        .cpu_dout  (cpu_dout),
        .cpu_empty (cpu_empty),
        .tx_level  (tx_level),
        .rx_level  (rx_level),
        .err_clr   (err_clr),
        .tx_ovf    (tx_ovf),
        .rx_unf    (rx_unf),
        .link_wr   (link_wr),
        .link_dout (link_dout),
        .link_dir  (link_dir),
        .link_rd   (link_rd),
        .link_din  (link_din),
        .link_dor  (link_dor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bookkeeping and reference model state
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_wr = -1;
    int         wr_pulses = 0;
    int         rd_pulses = 0;
    logic [7:0] tx_q[$];     // words accepted into TX, not yet seen on the link
    logic [7:0] rx_q[$];     // words held in RX, head first
    logic [7:0] src_q[$];    // words the link partner still has to deliver
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic       src_en = 1'b0;
    logic       consume = 1'b0;
    logic       dir_prev = 1'b0;
    logic       dor_prev = 1'b0;
    logic       rd_prev = 1'b0;
    int         rx_prev_size = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        src_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        consume = 1'b0;
        last_wr = -1;
        dir_prev = 1'b0;
        dor_prev = 1'b0;
        rd_prev = 1'b0;
        rx_prev_size = 0;
        link_dor = 1'b0;
        link_din = 8'h00;
    endtask

    // Link partner: once a word is offered it stays offered until consumed.
    task automatic drive_link();
        if (!link_dor && src_en && src_q.size() > 0) begin
            link_dor = 1'b1;
            link_din = src_q[0];
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_full"},  cpu_full,  0);
        check({tag, "_cpu_empty"}, cpu_empty, 1);
        check({tag, "_cpu_dout"},  cpu_dout,  0);
        check({tag, "_tx_level"},  tx_level,  0);
        check({tag, "_rx_level"},  rx_level,  0);
        check({tag, "_tx_ovf"},    tx_ovf,    0);
        check({tag, "_rx_unf"},    rx_unf,    0);
        check({tag, "_link_wr"},   link_wr,   0);
        check({tag, "_link_rd"},   link_rd,   0);
        check({tag, "_link_dout"}, link_dout, 0);
    endtask

    // One clock cycle. At the falling edge: compare the DUT against the
    // model, then apply this cycle's inputs to the model. Returns just
    // after the next rising edge.
    task automatic tick();
        logic       full_now;
        logic       unf_set;
        logic [7:0] exp_w;
        @(negedge clk);
        cyc++;
        $display("cyc %0d: wr=%0b din=%h rd=%0b clr=%0b dir=%0b dor=%0b | link_wr=%0b dout=%h link_rd=%0b txl=%0d rxl=%0d cpu_dout=%h",
                 cyc, cpu_wr, cpu_din, cpu_rd, err_clr, link_dir, link_dor,
                 link_wr, link_dout, link_rd, tx_level, rx_level, cpu_dout);

        // TX side: each link_wr pulse must carry the oldest accepted word.
        if (link_wr === 1'b1) begin
            wr_pulses++;
            check("wr_has_word", (tx_q.size() != 0), 1);
            check("wr_dir_prev", dir_prev, 1);
            if (last_wr >= 0) check("wr_spacing", ((cyc - last_wr) >= 3), 1);
            last_wr = cyc;
            if (tx_q.size() != 0) begin
                exp_w = tx_q.pop_front();
                check("link_dout", link_dout, exp_w);
            end
        end
        check("tx_level", tx_level, tx_q.size());
        check("cpu_full", cpu_full, (tx_q.size() == TXD));
        check("tx_ovf", tx_ovf, m_ovf);

        // RX side
        check("rx_level", rx_level, rx_q.size());
        check("cpu_empty", cpu_empty, (rx_q.size() == 0));
        if (rx_q.size() != 0) check("cpu_dout", cpu_dout, rx_q[0]);
        check("rx_unf", rx_unf, m_unf);
        if (link_rd === 1'b1) begin
            rd_pulses++;
            check("rd_room", (rx_prev_size < RXD), 1);
            check("rd_dor_prev", dor_prev, 1);
            check("rd_pulse_width", rd_prev, 0);
        end

        // Effects of the coming rising edge
        full_now = (tx_q.size() == TXD);
        if (cpu_wr && !full_now) tx_q.push_back(cpu_din);
        m_ovf = (cpu_wr && full_now) || (m_ovf && !err_clr);

        rx_prev_size = rx_q.size();
        unf_set = cpu_rd && (rx_q.size() == 0);
        if (cpu_rd && rx_q.size() != 0) void'(rx_q.pop_front());
        m_unf = unf_set || (m_unf && !err_clr);
        if (link_rd === 1'b1) begin
            check("rd_src_word", (src_q.size() != 0), 1);
            if (src_q.size() != 0) rx_q.push_back(src_q[0]);
            consume = 1'b1;
        end

        dir_prev = link_dir;
        dor_prev = link_dor;
        rd_prev  = link_rd;

        @(posedge clk);
        #1;
        if (consume) begin
            if (src_q.size() != 0) void'(src_q.pop_front());
            consume  = 1'b0;
            link_dor = 1'b0;
        end
        drive_link();
    endtask

    task automatic do_reset(input string tag);
        resetb = 1'b0;
        model_reset();
        #1;
        check_reset_vals(tag);
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals({tag, "_held"});
        resetb = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t2_words [5];
        int         snap;
        t2_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        resetb  = 1'b0;
        cpu_wr  = 1'b0;
        cpu_din = 8'h00;
        cpu_rd  = 1'b0;
        err_clr = 1'b0;
        link_dir = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        resetb = 1'b1;

        // 1: single word, 2-cycle latency to link_wr
        link_dir = 1'b1;
        cpu_wr   = 1'b1;
        cpu_din  = 8'hA5;
        tick();
        cpu_wr = 1'b0;
        check("t1_no_wr_yet", link_wr, 0);
        tick();
        check("t1_link_wr", link_wr, 1);
        check("t1_link_dout", link_dout, 8'hA5);
        tick();
        check("t1_wr_end", link_wr, 0);
        check("t1_tx_level", tx_level, 0);

        // 2: blocked link, overflow, then drain in order
        link_dir = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            cpu_wr  = 1'b1;
            cpu_din = t2_words[i];
            tick();
            if (i == 3) check("t2_full_after4", cpu_full, 1);
        end
        cpu_wr = 1'b0;
        check("t2_ovf", tx_ovf, 1);
        check("t2_level", tx_level, 4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t2_ovf_clr", tx_ovf, 0);
        snap = wr_pulses;
        link_dir = 1'b1;
        for (int i = 0; i < 40 && tx_q.size() != 0; i++) tick();
        check("t2_four_words", wr_pulses - snap, 4);
        tick();

        // 3: one received word, visible 2 cycles after link_dor
        snap = rd_pulses;
        src_q.push_back(8'h3C);
        src_en = 1'b1;
        drive_link();
        tick();
        check("t3_link_rd", link_rd, 1);
        check("t3_still_empty", cpu_empty, 1);
        tick();
        check("t3_not_empty", cpu_empty, 0);
        check("t3_dout", cpu_dout, 8'h3C);
        check("t3_rd_end", link_rd, 0);
        repeat (4) tick();
        check("t3_one_rd", rd_pulses - snap, 1);
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        check("t3_popped", cpu_empty, 1);

        // 4: RX full back-pressure
        snap = rd_pulses;
        for (int i = 0; i < 5; i++) src_q.push_back(8'($urandom));
        drive_link();
        repeat (20) tick();
        check("t4_four_rd", rd_pulses - snap, 4);
        check("t4_rx_full", rx_level, 4);
        check("t4_dor_held", link_dor, 1);
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        repeat (10) tick();
        check("t4_one_more_rd", rd_pulses - snap, 5);
        check("t4_rx_full_again", rx_level, 4);
        cpu_rd = 1'b1;
        repeat (4) tick();
        cpu_rd = 1'b0;
        check("t4_drained", cpu_empty, 1);
        src_en = 1'b0;

        // 5: underflow flag, clear, and set-beats-clear
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        check("t5_unf", rx_unf, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_clr", rx_unf, 0);
        cpu_rd = 1'b1;
        tick();
        check("t5_unf_again", rx_unf, 1);
        err_clr = 1'b1;
        tick();
        cpu_rd  = 1'b0;
        err_clr = 1'b0;
        check("t5_set_wins", rx_unf, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_clr2", rx_unf, 0);

        // 6: reset between link_wr pulses with 3 words still queued
        link_dir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_wr  = 1'b1;
            cpu_din = 8'($urandom);
            tick();
        end
        cpu_wr   = 1'b0;
        link_dir = 1'b1;
        for (int i = 0; i < 10 && link_wr !== 1'b1; i++) tick();
        check("t6_wr_seen", link_wr, 1);
        tick();
        check("t6_between", link_wr, 0);
        check("t6_queued", tx_level, 3);
        do_reset("t6_rst");
        snap = wr_pulses;
        repeat (10) tick();
        check("t6_no_wr_after_rst", wr_pulses - snap, 0);

        // 7: randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            cpu_wr   = ($urandom_range(0, 1) == 1);
            cpu_din  = 8'($urandom);
            cpu_rd   = ($urandom_range(0, 2) == 0);
            err_clr  = ($urandom_range(0, 9) == 0);
            link_dir = ($urandom_range(0, 3) != 0);
            src_en   = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0 && src_q.size() < 8) src_q.push_back(8'($urandom));
            drive_link();
            tick();
        end

        // 8: drain everything
        cpu_wr   = 1'b0;
        cpu_rd   = 1'b1;
        err_clr  = 1'b0;
        link_dir = 1'b1;
        src_en   = 1'b1;
        drive_link();
        for (int n = 0; n < 300 &&
             !(tx_q.size() == 0 && src_q.size() == 0 && rx_q.size() == 0 && !link_dor); n++) begin
            tick();
        end
        check("drain_done",
              (tx_q.size() == 0 && src_q.size() == 0 && rx_q.size() == 0 && !link_dor), 1);
        cpu_rd = 1'b0;
        repeat (3) tick();
        check("final_tx_level", tx_level, 0);
        check("final_rx_level", rx_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
